// File: rtl/not16_core_if.sv
// rtl/not16_core_if.sv - valid/ready handshake bundle for the pipelined Not16 path
//
// Signals:
//   in_data/in_valid/in_ready    producer -> core operand stream
//   out_data/out_valid/out_ready core -> consumer result stream
// Modports:
//   master  the surrounding logic (drives operands, accepts results)
//   slave   the core itself
interface not16_core_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/not16_core.sv
// rtl/not16_core.sv - Hack Not16 gate: combinational inverter plus registered skid-buffered copy
//
// Ports:
//   clk    rising-edge clock, used by the handshake path only
//   rst_n  asynchronous active-low reset
//   in     combinational operand
//   out    ~in, purely combinational
//   hs     slave side of not16_core_if: in_data/in_valid/in_ready accept operands,
//          out_data/out_valid/out_ready return ~operand in arrival order
module not16_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    not16_core_if.slave      hs
);

    // Zero-latency path, independent of clock and reset.
    assign out = ~in;

    // Occupancy of the 2-entry buffer doubles as the control state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_e;

    occ_e             state_q;
    occ_e             state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             head_load_in;
    logic             head_load_skid;
    logic             skid_load_in;
    logic             push;
    logic             pop;

    // Both handshake outputs come straight from the state register, so there is
    // no combinational path from out_ready to in_ready.
    assign hs.in_ready  = (state_q != S_FULL);
    assign hs.out_valid = (state_q != S_EMPTY);
    assign hs.out_data  = head_q;

    assign push = hs.in_valid & hs.in_ready;
    assign pop  = hs.out_valid & hs.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load_in   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_load_in = 1'b1;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        // Head is still waiting, so the new beat parks in the skid slot.
                        skid_load_in = 1'b1;
                        state_d      = S_FULL;
                    end
                    2'b01: begin
                        state_d = S_EMPTY;
                    end
                    2'b11: begin
                        // Old head leaves on this edge; the new beat replaces it directly.
                        head_load_in = 1'b1;
                    end
                    default: begin
                        state_d = S_ONE;
                    end
                endcase
            end
            S_FULL: begin
                // No push is possible here; a pop promotes the skid entry.
                if (pop) begin
                    head_load_skid = 1'b1;
                    state_d        = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // Data is inverted on entry so the output register is the result directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_load_in) begin
                head_q <= ~hs.in_data;
            end else if (head_load_skid) begin
                head_q <= skid_q;
            end
            if (skid_load_in) begin
                skid_q <= ~hs.in_data;
            end
        end
    end

endmodule

// File: tb/tb_not16_core.sv
// tb/tb_not16_core.sv - self-checking bench for not16_core
module tb_not16_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] comb_in;
    logic [15:0] comb_out;
    int          tests;
    int          fails;
    int          pops;
    int          sweep_fails;
    logic [15:0] sb[$];

    not16_core_if #(.WIDTH(16)) bus ();

    not16_core #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (comb_in),
        .out   (comb_out),
        .hs    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge between driver updates.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid_vs_model", {15'd0, bus.out_valid}, {15'd0, sb.size() != 0});
            check("in_ready_vs_model", {15'd0, bus.in_ready}, {15'd0, sb.size() < 2});
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                check("sb_out_data", bus.out_data, sb.pop_front());
                pops++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(~bus.in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
        end
        check("drain_empty", 16'(sb.size()), 16'd0);
    endtask

    initial begin
        logic [15:0] v;
        int          pops_start;

        tests         = 0;
        fails         = 0;
        pops          = 0;
        sweep_fails   = 0;
        rst_n         = 1'b0;
        comb_in       = 16'h0000;
        bus.in_data   = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out_data", bus.out_data, 16'h0000);
        check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);

        // Combinational directed values
        check("comb_0000", comb_out, 16'hFFFF);
        comb_in = 16'hA5F0;
        #1;
        check("comb_A5F0", comb_out, 16'h5A0F);

        step();
        rst_n = 1'b1;

        // Random sweep on the combinational path
        for (int i = 0; i < 10000; i++) begin
            v       = 16'($urandom);
            comb_in = v;
            #1;
            tests++;
            assert (comb_out === ~v) else begin
                fails++;
                sweep_fails++;
                $error("FAIL: a=%h, out=%h, expected=%h", v, comb_out, ~v);
            end
        end
        if (sweep_fails == 0) $display("[TB] random sweep passed");

        // Pipeline latency
        step();
        bus.out_ready = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        check("lat_out_valid", {15'd0, bus.out_valid}, 16'd1);
        check("lat_out_data", bus.out_data, 16'hEDCB);
        drain();

        // Backpressure: fill, refuse third beat, then release in order
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0001;
        bus.in_valid  = 1'b1;
        step();
        bus.in_data   = 16'h0002;
        step();
        check("bp_full_in_ready", {15'd0, bus.in_ready}, 16'd0);
        bus.in_data   = 16'h0003;
        step();
        check("bp_refused_in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("bp_hold_data", bus.out_data, 16'hFFFE);
        check("bp_hold_valid", {15'd0, bus.out_valid}, 16'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_pop1", bus.out_data, 16'hFFFE);
        step();
        check("bp_pop2", bus.out_data, 16'hFFFD);
        check("bp_pop2_valid", {15'd0, bus.out_valid}, 16'd1);
        check("bp_ready_back", {15'd0, bus.in_ready}, 16'd1);
        step();
        check("bp_empty", {15'd0, bus.out_valid}, 16'd0);
        drain();

        // Streaming: 100 back-to-back beats, never stalled
        pops_start    = pops;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_data  = 16'($urandom);
            bus.in_valid = 1'b1;
            check("stream_in_ready", {15'd0, bus.in_ready}, 16'd1);
            step();
        end
        bus.in_valid = 1'b0;
        drain();
        check("stream_count", 16'(pops - pops_start), 16'd100);

        // Reset mid-stream with the buffer full
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0F0F;
        bus.in_valid  = 1'b1;
        step();
        bus.in_data   = 16'h3C3C;
        step();
        bus.in_valid  = 1'b0;
        check("mid_full", {15'd0, bus.in_ready}, 16'd0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mid_rst_out_data", bus.out_data, 16'h0000);
        check("mid_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        comb_in = 16'h1357;
        #1;
        check("mid_rst_comb", comb_out, 16'hECA8);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_empty", {15'd0, bus.out_valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
